dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Sequences single data-memory accesses (LW, LBU, SB, SW) from the execute stage onto a handshaked data-memory port. Latches the decoded access, checks alignment, forms the word address, byte strobes and write data, and extracts the load result. Stalls the core until the access completes, then presents the writeback result or an error. Sits between the execute-stage load/store decode and the data memory.

Parameters:
TIMEOUT_CYCLES, 256, cycles spent in REQ+WAIT before the access is abandoned (>=2)
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
op_valid  in  1  execute stage presents a memory op
op_lw / op_lbu / op_sb / op_sw  in  1 each  op select, one-hot
op_addr  in  32  effective byte address
op_wdata  in  32  store data (SB uses [7:0])
op_rd  in  5  load destination register
stall  out  1  hold execute stage
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  32  word address, [1:0]=00
mem_wstrb  out  4  byte strobes
mem_wdata  out  32  write data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data
wb_valid  out  1  load result valid, one cycle
wb_rd  out  5  load destination
wb_data  out  32  load result
misalign_err  out  1  one-cycle pulse, misaligned LW/SW
timeout_err  out  1  one-cycle pulse, access abandoned
err_addr  out  32  faulting byte address

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, all outputs 0; an in-flight mem_req drops immediately; the memory must tolerate an abandoned request.
- Accept: in IDLE, op_valid=1 with exactly one op bit set. op_valid with zero or multiple op bits set is ignored (no stall, no access). op_valid is ignored outside IDLE; the latched copy drives the access.
- States: IDLE, REQ, WAIT, DONE.
- IDLE -> DONE on accept of LW/SW with op_addr[1:0]!=0, or SW... (LBU/SB never misalign). No memory access. DONE: misalign_err=1, err_addr=op_addr.
- IDLE -> REQ on any other accept; latch op, addr, wdata, rd; counter=0.
- REQ: mem_req=1; mem_we/mem_addr/mem_wstrb/mem_wdata held stable until mem_gnt. Store + gnt -> DONE. Load + gnt -> WAIT.
- WAIT: mem_req=0. mem_rvalid -> DONE, with wb_data and wb_rd registered on that edge. mem_rvalid is sampled only in WAIT; rvalid in the gnt cycle is ignored (memory returns data >=1 cycle after gnt).
- Timeout: the counter increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES-1 without progress -> DONE with timeout_err=1, err_addr=latched addr, wb_valid=0; mem_req drops.
- DONE: lasts exactly one cycle, then IDLE. wb_valid=1 only for a successfully completed load. op_valid is ignored in DONE, so the released instruction is not re-accepted.
- stall = (IDLE & accept) | REQ | WAIT; combinational. It is 0 in DONE and in IDLE without accept.
- Address/strobes: mem_addr={addr[31:2],2'b00}.
  - SW: wstrb=1111, wdata=op_wdata.
  - SB: wstrb=0001<<addr[1:0], wdata={4{op_wdata[7:0]}}.
  - Loads: we=0, wstrb=0000.
- Load data: LW wb_data=mem_rdata. LBU wb_data={24'b0, byte addr[1:0] of mem_rdata}, where lane 0 = [7:0].
- Loads with rd=0 still access memory; wb_valid still pulses, with wb_rd=0.
- wb_valid, misalign_err and timeout_err are mutually exclusive.
- Minimum op period: load 4 cycles (accept, gnt, rvalid, DONE); store 3 cycles.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt on first REQ cycle -> mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; stall high 2 cycles; DONE; no wb_valid.
- SB addr=0x203, wdata=0x5A -> mem_addr=0x200, wstrb=1000, wdata=0x5A5A5A5A.
- LBU addr=0x302, rdata=0x11223344, rvalid 3 cycles after gnt -> wb_valid=1 one cycle, wb_data=0x00000022, wb_rd=op_rd; stall low in DONE.
- LW addr=0x106 -> no mem_req; misalign_err=1, err_addr=0x106; back in IDLE 2 cycles after accept.
- LW, memory never asserts rvalid, TIMEOUT_CYCLES=8 -> timeout_err=1 after 8 REQ/WAIT cycles; wb_valid=0; next op is accepted normally.
- rst asserted while in WAIT -> mem_req, stall and all outputs 0 immediately; a late rvalid after reset is ignored; op_valid with two op bits set -> ignored, stall stays 0.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences one LW/LBU/SB/SW access at a time onto a
// handshaked data-memory port, stalling the execute stage until the access
// completes, then presents a load result, a misalignment error or a timeout.
module dmem_access_ctrl #(
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        op_lw,
    input  logic        op_lbu,
    input  logic        op_sb,
    input  logic        op_sw,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic [4:0]  op_rd,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic [31:0] err_addr
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lat_load;
    logic             lat_lbu;
    logic [31:0]      lat_addr;
    logic [4:0]       lat_rd;

    logic             one_hot;
    logic             accept;
    logic             misalign;
    logic [7:0]       load_byte;

    // Decode the incoming op: accept only a single op bit, flag misaligned words
    always_comb begin
        one_hot  = 1'b0;
        case ({op_lw, op_lbu, op_sb, op_sw})
            4'b1000, 4'b0100, 4'b0010, 4'b0001: one_hot = 1'b1;
            default:                            one_hot = 1'b0;
        endcase
        accept   = ~rst & op_valid & one_hot & (state == S_IDLE);
        misalign = (op_lw | op_sw) & (op_addr[1:0] != 2'b00);
        stall    = ~rst & (accept | (state == S_REQ) | (state == S_WAIT));
    end

    // Select the addressed byte lane of the returned word for LBU
    always_comb begin
        load_byte = mem_rdata[7:0];
        case (lat_addr[1:0])
            2'd0: load_byte = mem_rdata[7:0];
            2'd1: load_byte = mem_rdata[15:8];
            2'd2: load_byte = mem_rdata[23:16];
            2'd3: load_byte = mem_rdata[31:24];
            default: load_byte = mem_rdata[7:0];
        endcase
    end

    // Access sequencer: state, timeout counter, latched op and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            lat_load     <= 1'b0;
            lat_lbu      <= 1'b0;
            lat_addr     <= '0;
            lat_rd       <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wstrb    <= '0;
            mem_wdata    <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            err_addr     <= '0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (misalign) begin
                            state        <= S_DONE;
                            misalign_err <= 1'b1;
                            err_addr     <= op_addr;
                        end else begin
                            state     <= S_REQ;
                            cnt       <= '0;
                            lat_load  <= op_lw | op_lbu;
                            lat_lbu   <= op_lbu;
                            lat_addr  <= op_addr;
                            lat_rd    <= op_rd;
                            mem_req   <= 1'b1;
                            mem_we    <= op_sb | op_sw;
                            mem_addr  <= {op_addr[31:2], 2'b00};
                            if (op_sw) begin
                                mem_wstrb <= 4'b1111;
                                mem_wdata <= op_wdata;
                            end else if (op_sb) begin
                                mem_wstrb <= 4'b0001 << op_addr[1:0];
                                mem_wdata <= {4{op_wdata[7:0]}};
                            end else begin
                                mem_wstrb <= 4'b0000;
                                mem_wdata <= '0;
                            end
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        cnt     <= cnt + CNT_W'(1);
                        state   <= lat_load ? S_WAIT : S_DONE;
                    end else if (cnt >= CNT_LAST) begin
                        mem_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        err_addr    <= lat_addr;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= lat_rd;
                        wb_data  <= lat_lbu ? {24'b0, load_byte} : mem_rdata;
                        state    <= S_DONE;
                    end else if (cnt >= CNT_LAST) begin
                        timeout_err <= 1'b1;
                        err_addr    <= lat_addr;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed checks of the data-memory access controller
// with a short timeout so abandoned accesses are quick to reach.
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_lw, op_lbu, op_sb, op_sw;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [4:0]  op_rd;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;
    logic        timeout_err;
    logic [31:0] err_addr;

    int checks = 0;
    int errors = 0;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_lw(op_lw), .op_lbu(op_lbu), .op_sb(op_sb), .op_sw(op_sw),
        .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd),
        .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_err(misalign_err), .timeout_err(timeout_err), .err_addr(err_addr)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 2 time units after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present an op to the controller, then let combinational stall settle
    task automatic drive_op(input logic lw, input logic lbu, input logic sb, input logic sw,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        op_valid = 1'b1;
        op_lw = lw; op_lbu = lbu; op_sb = sb; op_sw = sw;
        op_addr = addr; op_wdata = wdata; op_rd = rd;
        #1;
    endtask

    task automatic clear_op();
        op_valid = 1'b0;
        op_lw = 1'b0; op_lbu = 1'b0; op_sb = 1'b0; op_sw = 1'b0;
        op_addr = '0; op_wdata = '0; op_rd = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_op();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b exp 0", stall); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b exp 0", mem_req); end
        checks++; if ({wb_valid, misalign_err, timeout_err} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b exp 000", {wb_valid, misalign_err, timeout_err}); end
        checks++; if (mem_addr !== 32'h0 || err_addr !== 32'h0 || wb_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got %h/%h/%h exp 0", mem_addr, err_addr, wb_data); end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sw();
        drive_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0);
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL sw_stall_accept got %b exp 1", stall); end
        tick();
        clear_op();
        mem_gnt = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("[TB] FAIL sw_req got req=%b we=%b exp 1/1", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'h0000_0100) begin errors++; $display("[TB] FAIL sw_addr got %h exp 00000100", mem_addr); end
        checks++; if (mem_wstrb !== 4'b1111) begin errors++; $display("[TB] FAIL sw_wstrb got %b exp 1111", mem_wstrb); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sw_wdata got %h exp deadbeef", mem_wdata); end
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL sw_stall_req got %b exp 1", stall); end
        tick();
        mem_gnt = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL sw_done got stall=%b req=%b exp 0/0", stall, mem_req); end
        checks++; if ({wb_valid, misalign_err, timeout_err} !== 3'b000) begin errors++; $display("[TB] FAIL sw_done_flags got %b exp 000", {wb_valid, misalign_err, timeout_err}); end
        tick();
    endtask

    task automatic test_sb();
        drive_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0203, 32'hFFFF_FF5A, 5'd0);
        tick();
        clear_op();
        #1;
        checks++; if (mem_addr !== 32'h0000_0200) begin errors++; $display("[TB] FAIL sb_addr got %h exp 00000200", mem_addr); end
        checks++; if (mem_wstrb !== 4'b1000) begin errors++; $display("[TB] FAIL sb_wstrb got %b exp 1000", mem_wstrb); end
        checks++; if (mem_wdata !== 32'h5A5A_5A5A) begin errors++; $display("[TB] FAIL sb_wdata got %h exp 5a5a5a5a", mem_wdata); end
        tick();
        checks++; if (mem_req !== 1'b1 || mem_wstrb !== 4'b1000 || stall !== 1'b1) begin errors++; $display("[TB] FAIL sb_hold got req=%b wstrb=%b stall=%b exp 1/1000/1", mem_req, mem_wstrb, stall); end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL sb_done got req=%b stall=%b exp 0/0", mem_req, stall); end
        tick();
    endtask

    task automatic test_lbu();
        drive_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0302, 32'h0, 5'd7);
        tick();
        clear_op();
        mem_gnt = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hAAAA_AAAA;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_wstrb !== 4'b0000) begin errors++; $display("[TB] FAIL lbu_req got req=%b we=%b wstrb=%b exp 1/0/0000", mem_req, mem_we, mem_wstrb); end
        checks++; if (mem_addr !== 32'h0000_0300) begin errors++; $display("[TB] FAIL lbu_addr got %h exp 00000300", mem_addr); end
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL lbu_wait got req=%b stall=%b wbv=%b exp 0/1/0", mem_req, stall, wb_valid); end
        tick();
        tick();
        mem_rvalid = 1'b1;
        mem_rdata = 32'h1122_3344;
        tick();
        mem_rvalid = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b1 || stall !== 1'b0) begin errors++; $display("[TB] FAIL lbu_done got wbv=%b stall=%b exp 1/0", wb_valid, stall); end
        checks++; if (wb_data !== 32'h0000_0022) begin errors++; $display("[TB] FAIL lbu_data got %h exp 00000022", wb_data); end
        checks++; if (wb_rd !== 5'd7) begin errors++; $display("[TB] FAIL lbu_rd got %0d exp 7", wb_rd); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL lbu_pulse got %b exp 0", wb_valid); end
    endtask

    task automatic test_lw_rd0();
        drive_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0, 5'd0);
        tick();
        clear_op();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd0) begin errors++; $display("[TB] FAIL lw_rd0 got wbv=%b rd=%0d exp 1/0", wb_valid, wb_rd); end
        checks++; if (wb_data !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL lw_data got %h exp cafef00d", wb_data); end
        tick();
    endtask

    task automatic test_misalign();
        drive_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0106, 32'h0, 5'd3);
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL mis_stall got %b exp 1", stall); end
        tick();
        clear_op();
        #1;
        checks++; if (misalign_err !== 1'b1 || err_addr !== 32'h0000_0106) begin errors++; $display("[TB] FAIL mis_lw got err=%b addr=%h exp 1/00000106", misalign_err, err_addr); end
        checks++; if (mem_req !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL mis_noacc got req=%b wbv=%b stall=%b exp 0/0/0", mem_req, wb_valid, stall); end
        tick();
        checks++; if (misalign_err !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_idle got err=%b req=%b exp 0/0", misalign_err, mem_req); end
        drive_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0101, 32'h1234_5678, 5'd0);
        tick();
        clear_op();
        #1;
        checks++; if (misalign_err !== 1'b1 || err_addr !== 32'h0000_0101 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_sw got err=%b addr=%h req=%b exp 1/00000101/0", misalign_err, err_addr, mem_req); end
        tick();
    endtask

    task automatic test_timeout();
        drive_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0700, 32'h0, 5'd9);
        tick();
        clear_op();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (timeout_err !== 1'b0 || stall !== 1'b1) begin errors++; $display("[TB] FAIL to_early%0d got err=%b stall=%b exp 0/1", i, timeout_err, stall); end
            tick();
        end
        #1;
        checks++; if (timeout_err !== 1'b0 || stall !== 1'b1) begin errors++; $display("[TB] FAIL to_last got err=%b stall=%b exp 0/1", timeout_err, stall); end
        tick();
        #1;
        checks++; if (timeout_err !== 1'b1 || wb_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL to_fire got err=%b wbv=%b stall=%b exp 1/0/0", timeout_err, wb_valid, stall); end
        checks++; if (err_addr !== 32'h0000_0700) begin errors++; $display("[TB] FAIL to_addr got %h exp 00000700", err_addr); end
        tick();
        drive_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 32'h0BAD_F00D, 5'd0);
        tick();
        clear_op();
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0500 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL to_next got req=%b addr=%h err=%b exp 1/00000500/0", mem_req, mem_addr, timeout_err); end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_flight();
        drive_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0600, 32'h0, 5'd4);
        tick();
        clear_op();
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got req=%b stall=%b exp 0/0", mem_req, stall); end
        tick();
        rst = 1'b0;
        tick();
        drive_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0604, 32'h0, 5'd4);
        tick();
        clear_op();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_wait got req=%b stall=%b addr=%h exp 0/0/0", mem_req, stall, mem_addr); end
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h5555_5555;
        tick();
        mem_rvalid = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_late_rvalid got wbv=%b stall=%b exp 0/0", wb_valid, stall); end
        drive_op(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0800, 32'h0, 5'd1);
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL multi_op_stall got %b exp 0", stall); end
        tick();
        #1;
        checks++; if (mem_req !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL multi_op_req got req=%b mis=%b exp 0/0", mem_req, misalign_err); end
        clear_op();
        tick();
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb();
        test_lbu();
        test_lw_rd0();
        test_misalign();
        test_timeout();
        test_reset_in_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
